// File: rtl/axis_reg.sv
// axis_reg: full-throughput AXI4-Stream register slice (output register plus skid register)
module axis_reg #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int LAST_ENABLE = 1,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_i,
  input  logic                  s_axis_tvalid_i,
  input  logic                  s_axis_tlast_i,
  input  logic [ID_WIDTH-1:0]   s_axis_tid_i,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest_i,
  input  logic [USER_WIDTH-1:0] s_axis_tuser_i,
  output logic                  s_axis_tready_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
  output logic                  m_axis_tvalid_o,
  output logic                  m_axis_tlast_o,
  output logic [ID_WIDTH-1:0]   m_axis_tid_o,
  output logic [DEST_WIDTH-1:0] m_axis_tdest_o,
  output logic [USER_WIDTH-1:0] m_axis_tuser_o,
  input  logic                  m_axis_tready_i
);
  localparam int BW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  logic [BW-1:0] in_beat, or_q, or_d, sr_q, sr_d;
  logic m_valid_q, m_valid_d, sr_valid_q, sr_valid_d, s_ready_q, s_ready_d;
  logic s_acc, or_free;
  logic [DATA_WIDTH-1:0] o_data;
  logic [KEEP_WIDTH-1:0] o_keep;
  logic                  o_last;
  logic [ID_WIDTH-1:0]   o_id;
  logic [DEST_WIDTH-1:0] o_dest;
  logic [USER_WIDTH-1:0] o_user;
  // Disabled fields are captured as constant zero so their register bits fold away.
  always_comb begin
    in_beat = {s_axis_tdata_i,
               KEEP_ENABLE != 0 ? s_axis_tkeep_i : {KEEP_WIDTH{1'b0}},
               LAST_ENABLE != 0 ? s_axis_tlast_i : 1'b0,
               ID_ENABLE != 0 ? s_axis_tid_i : {ID_WIDTH{1'b0}},
               DEST_ENABLE != 0 ? s_axis_tdest_i : {DEST_WIDTH{1'b0}},
               USER_ENABLE != 0 ? s_axis_tuser_i : {USER_WIDTH{1'b0}}};
    s_acc      = s_axis_tvalid_i & s_ready_q;
    or_free    = ~m_valid_q | m_axis_tready_i;
    or_d       = or_free ? (sr_valid_q ? sr_q : (s_acc ? in_beat : or_q)) : or_q;
    sr_d       = (~or_free & s_acc) ? in_beat : sr_q;
    m_valid_d  = or_free ? (sr_valid_q | s_acc) : 1'b1;
    sr_valid_d = or_free ? 1'b0 : (sr_valid_q | s_acc);
    s_ready_d  = ~sr_valid_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_q       <= '0;
      sr_q       <= '0;
      m_valid_q  <= 1'b0;
      sr_valid_q <= 1'b0;
      s_ready_q  <= 1'b0;
    end else begin
      or_q       <= or_d;
      sr_q       <= sr_d;
      m_valid_q  <= m_valid_d;
      sr_valid_q <= sr_valid_d;
      s_ready_q  <= s_ready_d;
    end
  end
  assign {o_data, o_keep, o_last, o_id, o_dest, o_user} = or_q;
  assign s_axis_tready_o = s_ready_q;
  assign m_axis_tvalid_o = m_valid_q;
  assign m_axis_tdata_o  = o_data;
  assign m_axis_tkeep_o  = KEEP_ENABLE != 0 ? o_keep : {KEEP_WIDTH{1'b1}};
  assign m_axis_tlast_o  = LAST_ENABLE != 0 ? o_last : 1'b1;
  assign m_axis_tid_o    = ID_ENABLE != 0 ? o_id : {ID_WIDTH{1'b0}};
  assign m_axis_tdest_o  = DEST_ENABLE != 0 ? o_dest : {DEST_WIDTH{1'b0}};
  assign m_axis_tuser_o  = USER_ENABLE != 0 ? o_user : {USER_WIDTH{1'b0}};
endmodule

// File: tb/tb_axis_reg.sv
// tb_axis_reg: scoreboard bench for axis_reg (128-bit full-sideband instance plus a 16-bit instance with keep/last disabled)
module tb_axis_reg;
  localparam int DW = 128;
  localparam int KW = 16;
  localparam int BW = DW + KW + 1 + 8 + 8 + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [DW-1:0] s_tdata, m_tdata;
  logic [KW-1:0] s_tkeep, m_tkeep;
  logic s_tvalid, s_tready, s_tlast, m_tvalid, m_tready, m_tlast;
  logic [7:0] s_tid, m_tid, s_tdest, m_tdest;
  logic [0:0] s_tuser, m_tuser;
  logic [15:0] b_s_tdata, b_m_tdata;
  logic [1:0] b_s_tkeep, b_m_tkeep;
  logic b_s_tvalid, b_s_tready, b_s_tlast, b_m_tvalid, b_m_tready, b_m_tlast;
  logic [7:0] b_s_tid, b_m_tid, b_s_tdest, b_m_tdest;
  logic [0:0] b_s_tuser, b_m_tuser;
  int total = 0;
  int bad = 0;
  logic [BW-1:0] sb[$];
  logic s_hs, m_hs;
  logic [BW-1:0] got, exp_b;

  axis_reg #(.DATA_WIDTH(DW), .ID_ENABLE(1), .DEST_ENABLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tlast_i(s_tlast), .s_axis_tid_i(s_tid), .s_axis_tdest_i(s_tdest),
    .s_axis_tuser_i(s_tuser), .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep), .m_axis_tvalid_o(m_tvalid),
    .m_axis_tlast_o(m_tlast), .m_axis_tid_o(m_tid), .m_axis_tdest_o(m_tdest),
    .m_axis_tuser_o(m_tuser), .m_axis_tready_i(m_tready)
  );

  axis_reg #(.DATA_WIDTH(16), .KEEP_ENABLE(0), .LAST_ENABLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata_i(b_s_tdata), .s_axis_tkeep_i(b_s_tkeep), .s_axis_tvalid_i(b_s_tvalid),
    .s_axis_tlast_i(b_s_tlast), .s_axis_tid_i(b_s_tid), .s_axis_tdest_i(b_s_tdest),
    .s_axis_tuser_i(b_s_tuser), .s_axis_tready_o(b_s_tready),
    .m_axis_tdata_o(b_m_tdata), .m_axis_tkeep_o(b_m_tkeep), .m_axis_tvalid_o(b_m_tvalid),
    .m_axis_tlast_o(b_m_tlast), .m_axis_tid_o(b_m_tid), .m_axis_tdest_o(b_m_tdest),
    .m_axis_tuser_o(b_m_tuser), .m_axis_tready_i(b_m_tready)
  );

  function automatic logic [BW-1:0] in_beat();
    return {s_tdata, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
  endfunction

  function automatic logic [BW-1:0] out_beat();
    return {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
  endfunction

  task automatic set_rand_in();
    s_tdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    s_tkeep = 16'($urandom());
    s_tlast = 1'($urandom());
    s_tid   = 8'($urandom());
    s_tdest = 8'($urandom());
    s_tuser = 1'($urandom());
  endtask

  // Called at a falling edge with inputs already driven: records the handshakes the
  // next rising edge will perform, updates the scoreboard, then advances one cycle.
  task automatic tick();
    #1;
    s_hs  = s_tvalid & s_tready;
    m_hs  = m_tvalid & m_tready;
    got   = out_beat();
    exp_b = '0;
    if (m_hs) exp_b = (sb.size() > 0) ? sb.pop_front() : ~got;
    if (s_hs) sb.push_back(in_beat());
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b0; m_tready = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tid = '0; s_tdest = '0; s_tuser = '0;
    b_s_tvalid = 1'b0; b_m_tready = 1'b0;
    b_s_tdata = '0; b_s_tkeep = '0; b_s_tlast = 1'b0; b_s_tid = '0; b_s_tdest = '0; b_s_tuser = '0;
    repeat (10) @(negedge clk);
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_s_tready got=%b exp=0", s_tready); end
    total++; if (m_tdata !== '0) begin bad++; $display("FAIL reset_m_tdata got=%h exp=0", m_tdata); end
    rst_n = 1'b1;
    #1;
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL release_s_tready_before_edge got=%b exp=0", s_tready); end
    @(negedge clk);
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL release_s_tready got=%b exp=1", s_tready); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL release_m_tvalid got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_stream();
    int stalls = 0, gaps = 0, outs = 0;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      set_rand_in();
      s_tlast = (i == 2047);
      tick();
      if (!s_hs) stalls++;
      if (i > 0 && !m_hs) gaps++;
      if (i == 0 && m_hs) gaps++;
      if (m_hs) begin
        outs++;
        total++; if (got !== exp_b) begin bad++; $display("FAIL stream_beat%0d got=%h exp=%h", outs, got, exp_b); end
      end
    end
    s_tvalid = 1'b0;
    tick();
    if (m_hs) begin
      outs++;
      total++; if (got !== exp_b) begin bad++; $display("FAIL stream_last_beat got=%h exp=%h", got, exp_b); end
    end
    total++; if (outs !== 2048) begin bad++; $display("FAIL stream_count got=%0d exp=2048", outs); end
    total++; if (stalls !== 0) begin bad++; $display("FAIL stream_input_stalls got=%0d exp=0", stalls); end
    total++; if (gaps !== 0) begin bad++; $display("FAIL stream_output_gaps got=%0d exp=0", gaps); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL stream_leftover got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tkeep = '1; s_tlast = 1'b0; s_tid = 8'h1; s_tdest = 8'h2; s_tuser = 1'b0;
    s_tdata = 128'hA;
    tick();
    s_tdata = 128'hB;
    tick();
    s_tdata = 128'hC;
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL bp_s_tready_drop got=%b exp=0", s_tready); end
    total++; if (m_tvalid !== 1'b1 || m_tdata !== 128'hA) begin bad++; $display("FAIL bp_hold_a got=%b/%h exp=1/a", m_tvalid, m_tdata); end
    tick();
    total++; if (s_hs !== 1'b0) begin bad++; $display("FAIL bp_c_ignored got=%b exp=0", s_hs); end
    total++; if (m_tvalid !== 1'b1 || m_tdata !== 128'hA) begin bad++; $display("FAIL bp_stable_a got=%b/%h exp=1/a", m_tvalid, m_tdata); end
    m_tready = 1'b1;
    for (int k = 0; k < 10 && n < 3; k++) begin
      tick();
      if (s_hs) s_tvalid = 1'b0;
      if (m_hs) begin
        n++;
        total++; if (got !== exp_b) begin bad++; $display("FAIL bp_order%0d got=%h exp=%h", n, got[BW-1 -: DW], exp_b[BW-1 -: DW]); end
      end
    end
    s_tvalid = 1'b0;
    total++; if (n !== 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", n); end
  endtask

  task automatic test_random();
    int viol = 0;
    logic hold;
    logic [BW-1:0] prev;
    for (int k = 0; k < 4000; k++) begin
      s_tvalid = 1'($urandom());
      m_tready = 1'($urandom());
      set_rand_in();
      hold = m_tvalid & ~m_tready;
      prev = out_beat();
      tick();
      if (m_hs) begin
        total++; if (got !== exp_b) begin bad++; $display("FAIL random_beat got=%h exp=%h", got, exp_b); end
      end
      if (hold && (m_tvalid !== 1'b1 || out_beat() !== prev)) viol++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (m_hs) begin
        total++; if (got !== exp_b) begin bad++; $display("FAIL random_drain got=%h exp=%h", got, exp_b); end
      end
    end
    total++; if (viol !== 0) begin bad++; $display("FAIL random_stability got=%0d exp=0", viol); end
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL random_leftover got=%0d exp=0", sb.size()); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL random_idle_tvalid got=%b exp=0", m_tvalid); end
  endtask

  task automatic test_disabled();
    logic [15:0] q[$];
    logic [15:0] e;
    int n = 0;
    b_m_tready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      b_s_tvalid = (k < 8);
      b_s_tdata = 16'(16'h1111 * (k + 1));
      b_s_tkeep = 2'b00; b_s_tlast = 1'b0;
      b_s_tid = 8'hFF; b_s_tdest = 8'hFF; b_s_tuser = 1'b1;
      #1;
      if (b_m_tvalid & b_m_tready) begin
        n++;
        e = (q.size() > 0) ? q.pop_front() : ~b_m_tdata;
        total++; if (b_m_tdata !== e) begin bad++; $display("FAIL dis_data got=%h exp=%h", b_m_tdata, e); end
        total++; if (b_m_tkeep !== 2'b11 || b_m_tlast !== 1'b1) begin bad++; $display("FAIL dis_keep_last got=%b/%b exp=11/1", b_m_tkeep, b_m_tlast); end
        total++; if (b_m_tid !== 8'h0 || b_m_tdest !== 8'h0 || b_m_tuser !== 1'b1) begin bad++; $display("FAIL dis_id_dest_user got=%h/%h/%b exp=0/0/1", b_m_tid, b_m_tdest, b_m_tuser); end
      end
      if (b_s_tvalid & b_s_tready) q.push_back(b_s_tdata);
      @(negedge clk);
    end
    b_s_tvalid = 1'b0;
    total++; if (n !== 8) begin bad++; $display("FAIL dis_count got=%0d exp=8", n); end
  endtask

  task automatic test_async_reset();
    int stale = 0;
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    set_rand_in();
    tick();
    set_rand_in();
    tick();
    s_tvalid = 1'b0;
    total++; if (s_tready !== 1'b0 || m_tvalid !== 1'b1) begin bad++; $display("FAIL ar_full got=%b/%b exp=0/1", s_tready, m_tvalid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin bad++; $display("FAIL ar_immediate got=%b/%b exp=0/0", m_tvalid, s_tready); end
    total++; if (m_tdata !== '0) begin bad++; $display("FAIL ar_data_clear got=%h exp=0", m_tdata); end
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_tready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (m_hs) stale++;
    end
    total++; if (stale !== 0) begin bad++; $display("FAIL ar_stale_beats got=%0d exp=0", stale); end
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL ar_ready_after got=%b exp=1", s_tready); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_disabled();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
